// File: rtl/data_memory.sv
// data_memory: word-organised data RAM for the core's memory stage, with a
// memory-mapped console transmit FIFO and a sticky access-error flag.
// Optional console: define DATA_MEMORY_CONSOLE_EN to build the FIFO and its
// CON_DATA/CON_STAT decode; otherwise the console outputs are tied low and the
// console addresses decode as unmapped.
module data_memory #(
    parameter logic [31:0] base_addr    = 32'h0000_0000,
    parameter int unsigned depth_words  = 1024,
    parameter logic [31:0] console_addr = 32'hFFFF_0000,
    parameter int unsigned fifo_depth   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        rd_wr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        con_overflow,
    output logic        acc_err
);

    localparam int unsigned AW        = $clog2(depth_words);
    localparam logic [32:0] RAM_BYTES = 33'(depth_words) << 2;

    logic [31:0] mem_q [depth_words];
    logic [31:0] rd_data_q;
    logic [31:0] rd_data_d;
    logic        acc_err_q;
    logic [32:0] offset_c;
    logic [AW-1:0] word_c;
    logic        ram_hit_c;
    logic        mapped_c;
    logic        wr_en_c;

    assign wr_en_c  = !rd_wr;
    assign offset_c = {1'b0, addr} - {1'b0, base_addr};
    assign word_c   = offset_c[AW+1:2];
    // A borrow out of the subtraction means addr lies below base_addr.
    assign ram_hit_c = (addr[1:0] == 2'b00) && !offset_c[32] && (offset_c < RAM_BYTES);

`ifdef DATA_MEMORY_CONSOLE_EN
    localparam int unsigned PW = $clog2(fifo_depth);
    localparam int unsigned CW = PW + 1;
    localparam logic [31:0] CON_STAT_ADDR = console_addr + 32'd4;

    logic [7:0]    fifo_q [fifo_depth];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic          con_data_hit_c;
    logic          con_stat_hit_c;
    logic          full_c;
    logic          pop_c;
    logic          push_req_c;
    logic          push_c;
    logic          drop_c;

    assign con_data_hit_c = (addr == console_addr);
    assign con_stat_hit_c = (addr == CON_STAT_ADDR);
    assign mapped_c       = ram_hit_c || con_data_hit_c || con_stat_hit_c;

    assign full_c     = (count_q == CW'(fifo_depth));
    assign pop_c      = (count_q != '0) && con_ready;
    assign push_req_c = wr_en_c && con_data_hit_c;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign push_c     = push_req_c && (!full_c || pop_c);
    assign drop_c     = push_req_c && full_c && !pop_c;

    // FIFO byte storage; not reset, validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (reset && push_c) begin
            fifo_q[wr_ptr_q] <= wr_data[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push_c && !pop_c) begin
                count_q <= count_q + CW'(1);
            end else if (pop_c && !push_c) begin
                count_q <= count_q - CW'(1);
            end
            if (drop_c) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign con_valid    = (count_q != '0);
    assign con_data     = con_valid ? fifo_q[rd_ptr_q] : 8'h00;
    assign con_overflow = overflow_q;
`else
    logic unused_c;

    assign mapped_c     = ram_hit_c;
    assign con_valid    = 1'b0;
    assign con_data     = 8'h00;
    assign con_overflow = 1'b0;
    assign unused_c     = ^{con_ready, console_addr, 32'(fifo_depth)};
`endif

    // RAM array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (reset && wr_en_c && ram_hit_c) begin
            mem_q[word_c] <= wr_data;
        end
    end

    // Read data selection for the decoded address.
    always_comb begin
        rd_data_d = 32'h0;
        if (ram_hit_c) begin
            rd_data_d = mem_q[word_c];
        end
`ifdef DATA_MEMORY_CONSOLE_EN
        else if (con_stat_hit_c) begin
            rd_data_d = {27'b0, full_c, 4'(count_q)};
        end
`endif
    end

    // Registered load data; held across write cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q <= 32'h0;
        end else if (rd_wr) begin
            rd_data_q <= rd_data_d;
        end
    end

    // Sticky flag for writes that hit no mapped location.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_err_q <= 1'b0;
        end else if (wr_en_c && !mapped_c) begin
            acc_err_q <= 1'b1;
        end
    end

    assign rd_data = rd_data_q;
    assign acc_err = acc_err_q;

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Word-organised data RAM on the processor core's memory-stage port.
- Consumes the core's data_addr, data_out and data_rd_wr; returns load data one cycle later, in time for the core's writeback stage.
- Also provides a memory-mapped console transmit FIFO with a valid/ready drain port toward the testbench or UART, and a sticky access-error flag.

Parameters:
- base_addr, 32'h0000_0000, byte address of RAM word 0.
- depth_words, 1024, RAM size in 32-bit words (power of two, 16..65536).
- console_addr, 32'hFFFF_0000, byte address of console data register; console_addr+4 is the status register.
- fifo_depth, 4, console FIFO entries (power of two, 2..16).

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-low (0 = in reset).
- addr  input  32  byte address from core (core data_addr).
- rd_wr  input  1  1 = read/idle, 0 = write (core data_rd_wr).
- wr_data  input  32  store data (core data_out).
- rd_data  output  32  load data to core (core data_in), registered.
- con_valid  output  1  console FIFO non-empty.
- con_data  output  8  head-of-FIFO byte.
- con_ready  input  1  consumer accepts head when con_valid & con_ready.
- con_overflow  output  1  sticky: console write dropped because FIFO full.
- acc_err  output  1  sticky: misaligned or unmapped write.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: rd_data=0, con_valid=0, con_data=0, con_overflow=0, acc_err=0.
  - FIFO pointers and count cleared.
  - RAM contents not reset.
- Decode, combinational on addr:
  - RAM hit: addr[1:0]==0 and base_addr <= addr < base_addr+4*depth_words. Word index = (addr-base_addr)>>2.
  - CON_DATA hit: addr==console_addr.
  - CON_STAT hit: addr==console_addr+4.
  - Anything else: unmapped.
- Write (rd_wr=0 at edge):
  - RAM hit: word written whole; rd_data holds its previous value.
  - CON_DATA hit: wr_data[7:0] pushed if FIFO not full; if full, byte dropped and con_overflow set.
  - CON_STAT hit: ignored.
  - Misaligned or unmapped: no state change except acc_err set.
- Read (rd_wr=1): every cycle, rd_data <= value for addr sampled at this edge, so the core sees it exactly one cycle after issuing the address.
  - RAM hit: stored word.
  - CON_STAT: {27'b0, full, count[3:0]} (count zero-extended to 4 bits).
  - CON_DATA, misaligned or unmapped: 32'h0.
  - Reads never set acc_err; the core drives rd_wr=1 when idle, so speculative reads must be harmless.
- Write followed by read of the same word on the next cycle returns the new data. No bypass is needed because the RAM is single-port with synchronous read.
- Console FIFO:
  - Circular buffer with wrap-around pointers and count 0..fifo_depth.
  - con_valid = (count!=0); con_data = entry at read pointer.
  - Pop occurs when con_valid & con_ready.
  - Push and pop in the same cycle:
    - Non-empty FIFO: both occur and count is unchanged.
    - Full FIFO: the push is accepted because a slot frees the same cycle, so no overflow.
    - Empty FIFO: only the push occurs; no same-cycle fall-through.
  - con_ready while empty: no effect.
- Sticky flags clear only on reset.
- Reset asserted mid-transfer: FIFO is emptied immediately; any write at that edge is lost.

Optional Feature:
- Macro: DATA_MEMORY_CONSOLE_EN.
- Defined: console FIFO, CON_DATA/CON_STAT decode and con_overflow function as above.
- Undefined: no FIFO logic is built. con_valid=0, con_data=0 and con_overflow=0 are tied off, con_ready is ignored, and console_addr/console_addr+4 decode as unmapped (writes set acc_err, reads return 0).

Test Plan:
- Write 32'hDEADBEEF to addr 32'h10, read 32'h10 next cycle -> rd_data=32'hDEADBEEF on the following edge; rd_data unchanged during the write cycle.
- Write 32'h1 to 32'h12 (misaligned) and to base_addr+4*depth_words (out of range) -> acc_err=1, RAM words 4 and 0 unchanged.
- With con_ready=0, write bytes 8'h41..8'h45 to console_addr (fifo_depth=4) -> status reads {full=1,count=4}, con_overflow=1, con_data=8'h41. Then raise con_ready -> drains 41,42,43,44 in order, con_valid=0 after 4 cycles.
- FIFO full plus console write with con_ready=1 in the same cycle -> count stays 4, con_overflow stays 0, new byte appears last in drain order.
- Assert reset mid-drain with count=3 -> con_valid, rd_data and flags go 0 without a clock edge; previously written RAM word still reads back correctly after reset release.
- Build without DATA_MEMORY_CONSOLE_EN, write to console_addr -> acc_err=1, con_valid stays 0.
